// File: rtl/spi_slave_if_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_if_gen
// Description : Oversampled SPI slave front end. Synchronises sclk/ss_n/mosi
//               into clk, deframes {cmd[1:0], payload} frames and serialises
//               read data back on miso with a ready/valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_if_gen #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sclk,
    input  logic              i_ss_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic [DATA_W+1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic              o_frame_err
);

    localparam int                 c_FRAME_W     = DATA_W + 2;
    localparam int                 c_CNT_W       = $clog2(DATA_W + 3);
    localparam logic [c_CNT_W-1:0] c_CNT_RX_LAST = c_CNT_W'(c_FRAME_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_TX_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic               c_SCLK_IDLE   = (CPOL != 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV    = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_SEND = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [SYNC_STAGES-1:0]   r_sclk_sync;
    logic [SYNC_STAGES-1:0]   r_ss_sync;
    logic [SYNC_STAGES-1:0]   r_mosi_sync;
    logic [SYNC_STAGES-1:0]   r_flush;
    logic                     r_sclk_d;

    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_has_rd;
    logic                     r_armed;
    logic [c_FRAME_W-2:0]     r_rx_sh;
    logic [DATA_W-1:0]        r_tx_sh;
    logic                     r_smp;
    logic [c_FRAME_W-1:0]     r_rx_data;
    logic                     r_rxv_pend;
    logic                     r_rx_valid;
    logic                     r_frame_err;

    logic                     w_sclk_s;
    logic                     w_ss_s;
    logic                     w_mosi_s;
    logic                     w_flushed;
    logic                     w_rise;
    logic                     w_fall;
    logic                     w_lead;
    logic                     w_trail;
    logic                     w_sample;
    logic                     w_shift;
    logic [c_FRAME_W-1:0]     w_frame;
    logic [1:0]               w_cmd;

    logic                     w_clr_cnt;
    logic                     w_inc_cnt;
    logic                     w_shift_rx;
    logic                     w_load_rx;
    logic                     w_set_rd;
    logic                     w_clr_rd;
    logic                     w_err;
    logic                     w_load_tx;
    logic                     w_shift_tx;
    logic                     w_set_smp;

    // Input synchronisers reset to the bus idle levels; r_flush marks when
    // the chains hold real pin samples so a low ss_n held through reset is
    // not mistaken for a fresh select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{c_SCLK_IDLE}};
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_flush     <= '0;
            r_sclk_d    <= c_SCLK_IDLE;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_flushed = &r_flush;

    assign w_rise   = w_sclk_s & ~r_sclk_d;
    assign w_fall   = ~w_sclk_s & r_sclk_d;
    assign w_lead   = (CPOL == 0) ? w_rise : w_fall;
    assign w_trail  = (CPOL == 0) ? w_fall : w_rise;
    assign w_sample = (CPHA == 0) ? w_lead : w_trail;
    assign w_shift  = (CPHA == 0) ? w_trail : w_lead;

    // The bit arriving on this sample edge completes the frame.
    assign w_frame = {r_rx_sh, w_mosi_s};
    assign w_cmd   = w_frame[c_FRAME_W-1 -: 2];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath control; ss_n abort beats everything.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_cnt   = 1'b0;
        w_inc_cnt   = 1'b0;
        w_shift_rx  = 1'b0;
        w_load_rx   = 1'b0;
        w_set_rd    = 1'b0;
        w_clr_rd    = 1'b0;
        w_err       = 1'b0;
        w_load_tx   = 1'b0;
        w_shift_tx  = 1'b0;
        w_set_smp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && !w_ss_s) begin
                    w_state_nxt = ST_RECV;
                    w_clr_cnt   = 1'b1;
                end
            end
            ST_RECV: begin
                if (w_ss_s) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = (r_cnt != '0);
                end else if (w_sample) begin
                    w_shift_rx = 1'b1;
                    w_inc_cnt  = 1'b1;
                    if (r_cnt == c_CNT_RX_LAST) begin
                        w_state_nxt = ST_HOLD;
                        case (w_cmd)
                            2'b10: begin
                                w_load_rx = 1'b1;
                                w_set_rd  = 1'b1;
                            end
                            2'b11: begin
                                if (r_has_rd) begin
                                    w_load_rx   = 1'b1;
                                    w_state_nxt = ST_RD_WAIT;
                                end else begin
                                    w_err = 1'b1;
                                end
                            end
                            default: w_load_rx = 1'b1;
                        endcase
                    end
                end
            end
            ST_RD_WAIT: begin
                if (w_ss_s) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = 1'b1;
                end else if (w_sample) begin
                    w_state_nxt = ST_HOLD;
                    w_err       = 1'b1;
                end else if (i_tx_valid) begin
                    w_state_nxt = ST_RD_SEND;
                    w_load_tx   = 1'b1;
                    w_clr_cnt   = 1'b1;
                    w_clr_rd    = 1'b1;
                end
            end
            ST_RD_SEND: begin
                if (w_ss_s) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = 1'b1;
                end else if (w_sample) begin
                    w_inc_cnt = 1'b1;
                    w_set_smp = 1'b1;
                    if (r_cnt == c_CNT_TX_LAST) begin
                        w_state_nxt = ST_HOLD;
                    end
                end else if (w_shift && r_smp) begin
                    w_shift_tx = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_ss_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame datapath: counters, shift registers and output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_has_rd    <= 1'b0;
            r_armed     <= 1'b0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_smp       <= 1'b0;
            r_rx_data   <= '0;
            r_rxv_pend  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rxv_pend  <= w_load_rx;
            r_rx_valid  <= r_rxv_pend;
            r_frame_err <= w_err;

            if (r_state != ST_IDLE) begin
                r_armed <= 1'b0;
            end else if (w_flushed && w_ss_s) begin
                r_armed <= 1'b1;
            end

            if (w_clr_cnt) begin
                r_cnt <= '0;
            end else if (w_inc_cnt) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_shift_rx) begin
                r_rx_sh <= w_frame[c_FRAME_W-2:0];
            end
            if (w_load_rx) begin
                r_rx_data <= w_frame;
            end

            if (w_set_rd) begin
                r_has_rd <= 1'b1;
            end else if (w_clr_rd) begin
                r_has_rd <= 1'b0;
            end

            if (w_load_tx) begin
                r_tx_sh <= i_tx_data;
            end else if (w_shift_tx) begin
                r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
            end

            if (w_load_tx || w_shift_tx) begin
                r_smp <= 1'b0;
            end else if (w_set_smp) begin
                r_smp <= 1'b1;
            end
        end
    end

    assign o_miso_oe   = (r_state == ST_RD_SEND);
    assign o_miso      = (r_state == ST_RD_SEND) & r_tx_sh[DATA_W-1];
    assign o_tx_ready  = (r_state == ST_RD_WAIT);
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;

endmodule
`default_nettype wire
